tmnt_priority_mixer: RTL
========================

Name: tmnt_priority_mixer

Overview:
- Upstream neighbour of the palette/colour stage.
- Each pixel, takes the fix layer, the two scroll layers (A, B) and the sprite pixel, resolves transparency and priority, and emits the 10-bit palette index CD, SHADOW and NCBLK that the colour stage latches on V6M.
- A CPU-writable mode register selects layer order, sprite-over-all and shadow enable; it is double-buffered so changes apply only at line boundaries.

Parameters:
- PIPE_EXTRA, 0, additional output register stages (0..2) to match the colour stage's video alignment; applies equally to CD, SHADOW and NCBLK.

Ports:
- V6M  in  1  pixel clock; all state changes on its rising edge
- RESET  in  1  synchronous, active-high reset
- HBLK  in  1  horizontal blank, active high
- VBLK  in  1  vertical blank, active high
- FIX_COL  in  8  fix pixel: [7:4] palette bank, [3:0] pen; pen 0 is transparent
- LA_COL  in  8  scroll layer A pixel; same format
- LB_COL  in  8  scroll layer B pixel; same format
- OBJ_COL  in  8  sprite pixel; same format
- OBJ_PRI  in  1  1 = sprite sits behind the front scroll layer
- OBJ_SHD  in  1  1 = opaque sprite pixel is a shadow pixel
- PRI_WR  in  1  one-cycle strobe; writes CPU_DIN[2:0] to the pending mode register
- CPU_DIN  in  8  CPU write data; bits [7:3] ignored
- CPU_DOUT  out  8  {5'b0, pending mode}; always driven
- CD  out  10  palette index: [9:8] source (00 fix, 01 A, 10 B, 11 sprite), [7:0] colour
- SHADOW  out  1  shadow flag for the colour stage
- NCBLK  out  1  active-low composite blank

Behaviour:
- Mode bits: [0] SWAP (0: A in front of B; 1: B in front of A), [1] OBJ_TOP (forces OBJ_PRI to be treated as 0), [2] SHD_EN.
- Mode register path:
  - PRI_WR loads pending <= CPU_DIN[2:0].
  - On the cycle HBLK is 1 and HBLK was 0 last cycle, active <= pending. If PRI_WR is high in that same cycle, active takes CPU_DIN[2:0] directly.
  - Active never changes mid-line.
- Stage 1 (registered): all pixel inputs, HBLK|VBLK, and per-source opaque flags (pen != 0).
- Stage 2 (registered): resolve and drive outputs. Base latency is 2 V6M cycles from inputs to CD/SHADOW/NCBLK, plus PIPE_EXTRA.
- Resolve order, front to back (F = front scroll layer, K = back scroll layer per SWAP; P = OBJ_PRI & ~OBJ_TOP):
  - Fix, then sprite (if P=0), then F, then sprite (if P=1), then K.
  - The first opaque source wins.
  - If every source is transparent, output the backdrop: CD = {K source code, K colour} as-is (pen 0 of K's bank).
- Shadow handling:
  - If the winning source is a sprite with OBJ_SHD=1 and SHD_EN=1, the sprite colour is not output. Resolution continues to the next source behind it, and SHADOW=1.
  - If the same case occurs with SHD_EN=0, the sprite pixel is output normally with SHADOW=0.
  - A shadow sprite hidden behind an opaque layer gives SHADOW=0.
- Blanking: if the delayed HBLK|VBLK is 1, then NCBLK=0, CD=0 and SHADOW=0. Otherwise NCBLK=1.
- Reset:
  - CD=0, SHADOW=0, NCBLK=0.
  - Pending=0 and active=0.
  - All pipeline registers cleared.
  - Reset mid-line discards in-flight pixels. Outputs stay blanked until the pipeline refills, i.e. for at least 2+PIPE_EXTRA cycles after RESET falls.
- No combinational path from any input to CD/SHADOW/NCBLK. CPU_DOUT is combinational from pending.

Test Plan:
- Reset, HBLK=VBLK=0, FIX_COL=8'h00, LA_COL=8'h35, LB_COL=8'h47, OBJ_COL=0, mode 0 -> during reset and 1 cycle after, NCBLK=0 and CD=0; then CD=10'h135 two cycles after inputs applied, NCBLK=1.
- FIX_COL=8'h21 with all others opaque -> CD=10'h021; FIX_COL=8'h20 (transparent) -> CD=10'h3xx (sprite) when OBJ_COL=8'h5A, OBJ_PRI=0 -> CD=10'h35A.
- OBJ_PRI=1, LA_COL=8'h13, OBJ_COL=8'h5A, mode SWAP=0 -> CD=10'h113. Write mode 3'b010 mid-line -> output unchanged until the next HBLK rise, then CD=10'h35A. CPU_DOUT=8'h02 immediately after the write.
- SWAP: LA_COL=8'h13, LB_COL=8'h24, others transparent, write mode 3'b001 and pulse HBLK -> CD=10'h224. All pens 0 with LA_COL=8'h30, SWAP=1 -> backdrop CD=10'h130.
- Shadow: mode 3'b100, OBJ_COL=8'h5A, OBJ_SHD=1, OBJ_PRI=0, LA_COL=8'h13 -> CD=10'h113, SHADOW=1. Same stimulus with mode 0 -> CD=10'h35A, SHADOW=0.
- Blank/edge: assert VBLK for 3 cycles mid-stream -> NCBLK=0 and CD=0 for exactly 3 cycles, delayed 2 cycles. PRI_WR coincident with the HBLK rising edge -> the new value becomes active that edge.

Source files
------------

// File: rtl/tmnt_priority_mixer.sv
// tmnt_priority_mixer
// Per-pixel layer mixer that sits in front of the palette/colour stage.
// It takes the fix layer, scroll layers A and B and the sprite pixel,
// resolves transparency and priority, and produces the 10-bit palette
// index, shadow flag and composite blank that the colour stage latches.
//
// Ports:
//   V6M             pixel clock, all state changes on its rising edge
//   RESET           synchronous, active-high reset
//   HBLK, VBLK      horizontal / vertical blank, active high
//   FIX_COL         fix pixel     [7:4] bank, [3:0] pen (pen 0 transparent)
//   LA_COL, LB_COL  scroll A / B pixels, same format
//   OBJ_COL         sprite pixel, same format
//   OBJ_PRI         1 = sprite sits behind the front scroll layer
//   OBJ_SHD         1 = opaque sprite pixel is a shadow pixel
//   PRI_WR          CPU strobe, loads CPU_DIN[2:0] into the pending mode
//   CPU_DIN         CPU write data (bits [7:3] unused)
//   CPU_DOUT        {5'b0, pending mode}
//   CD              palette index: [9:8] source (00 fix, 01 A, 10 B, 11 sprite)
//   SHADOW          shadow flag for the colour stage
//   NCBLK           active-low composite blank
//
// Mode bits: [0] SWAP (B in front of A), [1] OBJ_TOP (ignore OBJ_PRI),
//            [2] SHD_EN (shadow sprites darken instead of drawing).

module tmnt_priority_mixer #(
   parameter int PIPE_EXTRA = 0
) (
   input  logic       V6M,
   input  logic       RESET,
   input  logic       HBLK,
   input  logic       VBLK,
   input  logic [7:0] FIX_COL,
   input  logic [7:0] LA_COL,
   input  logic [7:0] LB_COL,
   input  logic [7:0] OBJ_COL,
   input  logic       OBJ_PRI,
   input  logic       OBJ_SHD,
   input  logic       PRI_WR,
   input  logic [7:0] CPU_DIN,
   output logic [7:0] CPU_DOUT,
   output logic [9:0] CD,
   output logic       SHADOW,
   output logic       NCBLK
);

   // Mode register: pending is CPU-visible, active is what the mixer uses
   logic [2:0] pending_mode;
   logic [2:0] active_mode;
   logic       hblk_last;
   logic       unused_din;

   assign unused_din = ^CPU_DIN[7:3];
   assign CPU_DOUT   = {5'b00000, pending_mode};

   // The active mode only moves on the rising edge of HBLK so a line is
   // never drawn with two different modes. A write landing on that very
   // edge goes straight through to active.
   always_ff @(posedge V6M) begin
      if (RESET) begin
         pending_mode <= 3'b000;
         active_mode  <= 3'b000;
         hblk_last    <= 1'b0;
      end else begin
         if (PRI_WR)
            pending_mode <= CPU_DIN[2:0];
         if (HBLK && !hblk_last)
            active_mode <= PRI_WR ? CPU_DIN[2:0] : pending_mode;
         hblk_last <= HBLK;
      end
   end

   // Stage 1: register the pixel inputs together with the mode in force
   // when they arrived. s1_valid stays low after reset so the outputs are
   // held blank until real pixels have reached the output.
   logic       s1_valid;
   logic       s1_blank;
   logic [7:0] s1_fix, s1_la, s1_lb, s1_obj;
   logic       s1_fix_op, s1_la_op, s1_lb_op, s1_obj_op;
   logic       s1_obj_pri, s1_obj_shd;
   logic [2:0] s1_mode;

   always_ff @(posedge V6M) begin
      if (RESET) begin
         s1_valid   <= 1'b0;
         s1_blank   <= 1'b0;
         s1_fix     <= 8'h00;
         s1_la      <= 8'h00;
         s1_lb      <= 8'h00;
         s1_obj     <= 8'h00;
         s1_fix_op  <= 1'b0;
         s1_la_op   <= 1'b0;
         s1_lb_op   <= 1'b0;
         s1_obj_op  <= 1'b0;
         s1_obj_pri <= 1'b0;
         s1_obj_shd <= 1'b0;
         s1_mode    <= 3'b000;
      end else begin
         s1_valid   <= 1'b1;
         s1_blank   <= HBLK | VBLK;
         s1_fix     <= FIX_COL;
         s1_la      <= LA_COL;
         s1_lb      <= LB_COL;
         s1_obj     <= OBJ_COL;
         s1_fix_op  <= (FIX_COL[3:0] != 4'h0);
         s1_la_op   <= (LA_COL[3:0]  != 4'h0);
         s1_lb_op   <= (LB_COL[3:0]  != 4'h0);
         s1_obj_op  <= (OBJ_COL[3:0] != 4'h0);
         s1_obj_pri <= OBJ_PRI;
         s1_obj_shd <= OBJ_SHD;
         s1_mode    <= active_mode;
      end
   end

   // Stage 2 resolve. A shadow sprite (with shadow enabled) never supplies
   // colour; it only raises SHADOW when nothing in front of it is opaque,
   // and resolution carries on to whatever is behind it.
   logic [7:0] front_col, back_col;
   logic [1:0] front_code, back_code;
   logic       front_op;
   logic       obj_behind;
   logic       obj_is_shadow;
   logic       obj_draws;
   logic [9:0] res_cd;
   logic       res_shadow;
   logic       res_ncblk;

   always_comb begin
      front_col     = s1_mode[0] ? s1_lb    : s1_la;
      front_code    = s1_mode[0] ? 2'b10    : 2'b01;
      front_op      = s1_mode[0] ? s1_lb_op : s1_la_op;
      back_col      = s1_mode[0] ? s1_la    : s1_lb;
      back_code     = s1_mode[0] ? 2'b01    : 2'b10;
      obj_behind    = s1_obj_pri & ~s1_mode[1];
      obj_is_shadow = s1_obj_op & s1_obj_shd & s1_mode[2];
      obj_draws     = s1_obj_op & ~obj_is_shadow;

      res_cd     = {back_code, back_col};
      res_shadow = obj_is_shadow & ~s1_fix_op & ~(obj_behind & front_op);
      res_ncblk  = 1'b1;

      if (s1_fix_op)
         res_cd = {2'b00, s1_fix};
      else if (!obj_behind && obj_draws)
         res_cd = {2'b11, s1_obj};
      else if (front_op)
         res_cd = {front_code, front_col};
      else if (obj_behind && obj_draws)
         res_cd = {2'b11, s1_obj};

      if (!s1_valid || s1_blank) begin
         res_cd     = 10'h000;
         res_shadow = 1'b0;
         res_ncblk  = 1'b0;
      end
   end

   // Output register plus PIPE_EXTRA alignment stages, packed as
   // {NCBLK, SHADOW, CD}. Reset clears every stage so outputs read blank.
   logic [11:0] out_pipe [0:PIPE_EXTRA];

   always_ff @(posedge V6M) begin
      if (RESET) begin
         for (int i = 0; i <= PIPE_EXTRA; i++)
            out_pipe[i] <= 12'h000;
      end else begin
         out_pipe[0] <= {res_ncblk, res_shadow, res_cd};
         for (int i = 1; i <= PIPE_EXTRA; i++)
            out_pipe[i] <= out_pipe[i-1];
      end
   end

   assign CD     = out_pipe[PIPE_EXTRA][9:0];
   assign SHADOW = out_pipe[PIPE_EXTRA][10];
   assign NCBLK  = out_pipe[PIPE_EXTRA][11];

endmodule
